// File: rtl/prog_loader_if.sv
// prog_loader_if: program stream input and instruction-RAM write bus
interface prog_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  modport master (output in_data, in_valid, input in_ready, mem_wren, mem_addr, mem_data);
  modport slave  (input in_data, in_valid, output in_ready, mem_wren, mem_addr, mem_data);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: loads a framed program stream (length, data, checksum) into instruction RAM
module prog_loader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_start,
  prog_loader_if.slave      bus,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_word_count
);
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  localparam logic [ADDR_W-1:0] LP_BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [DATA_W:0]   LP_DEPTH = (DATA_W+1)'(DEPTH);
  state_t            r_state, w_state_n;
  logic [ADDR_W-1:0] r_len, w_len_n;
  logic [DATA_W-1:0] r_sum, w_sum_n;
  logic [ADDR_W-1:0] r_word_count, w_cnt_n;
  logic              r_mem_wren, w_wren_n;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_n;
  logic [DATA_W-1:0] r_mem_data, w_data_n;
  logic              r_busy, r_done, r_err;
  logic              w_xfer, w_busy_n;
  logic [ADDR_W-1:0] w_cnt_inc;
  assign w_xfer    = bus.in_valid & r_busy;
  assign w_cnt_inc = r_word_count + ADDR_W'(1);
  assign w_busy_n  = (w_state_n == S_LEN) | (w_state_n == S_DATA) | (w_state_n == S_CSUM);
  assign bus.in_ready = r_busy;
  assign bus.mem_wren = r_mem_wren;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_data = r_mem_data;
  assign o_cpu_hold   = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_word_count = r_word_count;
  // Next-state and next-output decode; every register is loaded from these values
  always_comb begin
    w_state_n = r_state;
    w_len_n   = r_len;
    w_sum_n   = r_sum;
    w_cnt_n   = r_word_count;
    w_wren_n  = 1'b0;
    w_addr_n  = r_mem_addr;
    w_data_n  = r_mem_data;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (i_load_start) begin
        w_state_n = S_LEN;
        w_sum_n   = '0;
        w_cnt_n   = '0;
      end
      S_LEN: if (w_xfer) begin
        w_len_n   = ADDR_W'(bus.in_data);
        w_state_n = ({1'b0, bus.in_data} > LP_DEPTH) ? S_ERR : (bus.in_data == '0) ? S_CSUM : S_DATA;
      end
      S_DATA: if (w_xfer) begin
        w_wren_n  = 1'b1;
        w_addr_n  = LP_BASE + r_word_count;
        w_data_n  = bus.in_data;
        w_cnt_n   = w_cnt_inc;
        w_sum_n   = r_sum + bus.in_data;
        w_state_n = (w_cnt_inc == r_len) ? S_CSUM : S_DATA;
      end
      S_CSUM: if (w_xfer) w_state_n = (bus.in_data == r_sum) ? S_DONE : S_ERR;
      default: w_state_n = S_IDLE;
    endcase
  end
  // State and registered outputs; status flags follow the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_sum        <= '0;
      r_word_count <= '0;
      r_mem_wren   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_len        <= w_len_n;
      r_sum        <= w_sum_n;
      r_word_count <= w_cnt_n;
      r_mem_wren   <= w_wren_n;
      r_mem_addr   <= w_addr_n;
      r_mem_data   <= w_data_n;
      r_busy       <= w_busy_n;
      r_done       <= (w_state_n == S_DONE);
      r_err        <= (w_state_n == S_ERR);
    end
  end
endmodule
